pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 82 ++++++++
 tb/tb_pipeline_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/redirect control with data-memory wait FSM; PIPE_CTRL_PERF_EN adds stall_cnt
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic       mem_jump,
    input  logic       mem_access,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       en_pc,
    output logic       en_if_id,
    output logic       en_id_ex,
    output logic       en_ex_mem,
    output logic       en_mem_wb,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_ex_mem,
    output logic       pc_sel,
    output logic       timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int cw = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    state_t state, state_nx;
    logic [cw-1:0] cnt, cnt_nx;
    logic redirect, load_use, go, live;
    assign redirect = mem_jump | (mem_branch & mem_zero);
    assign load_use = ex_memread && ex_rd != 5'd0 &&
                      (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // go: the pipeline may advance this cycle, so hazards get evaluated
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go       = 1'b0;
        if (state == RUN) begin
            go       = !(mem_access && !dmem_ack);
            state_nx = go ? RUN : MEM_WAIT;
            cnt_nx   = go ? '0 : cw'(1);
        end else if (state == MEM_WAIT) begin
            go       = dmem_ack;
            state_nx = dmem_ack ? RUN : (cnt == cw'(MEM_TIMEOUT) ? ERR : MEM_WAIT);
            cnt_nx   = dmem_ack ? '0 : cnt + 1'b1;
        end
        live         = go && !rst;
        pc_sel       = live && redirect;
        flush_if_id  = pc_sel;
        flush_ex_mem = pc_sel;
        flush_id_ex  = live && (redirect || load_use);
        en_pc        = live && (redirect || !load_use);
        en_if_id     = en_pc;
        en_id_ex     = live;
        en_ex_mem    = live;
        en_mem_wb    = live;
        dmem_req     = !rst && (state == MEM_WAIT || (state == RUN && mem_access));
        timeout_err  = state == ERR;
    end
`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        stall_cnt <= rst ? '0 : stall_cnt + {31'd0, !en_pc};
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl hazards, memory wait, timeout and reset
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_memread, mem_branch, mem_zero, mem_jump, mem_access, dmem_ack;
    logic dmem_req, en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, pc_sel, timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif
    int passes = 0;
    int total = 0;
    // {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb, flush_if_id,flush_id_ex,flush_ex_mem, pc_sel,dmem_req,timeout_err}
    localparam logic [10:0] IDLE  = 11'b11111_000_000;
    localparam logic [10:0] IDLEM = 11'b11111_000_010;
    localparam logic [10:0] LU    = 11'b00111_010_000;
    localparam logic [10:0] LUM   = 11'b00111_010_010;
    localparam logic [10:0] RDR   = 11'b11111_111_100;
    localparam logic [10:0] RDRM  = 11'b11111_111_110;
    localparam logic [10:0] STALL = 11'b00000_000_010;
    localparam logic [10:0] ERRS  = 11'b00000_000_001;
    localparam logic [10:0] ZERO  = 11'b00000_000_000;
    logic [10:0] outs;
    assign outs = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, flush_ex_mem, pc_sel, dmem_req, timeout_err};

    pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .pc_sel(pc_sel), .timeout_err(timeout_err)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_outs(input string tag, input logic [10:0] e);
        #1;
        check(tag, {21'd0, outs}, {21'd0, e});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs2, ex_memread, mem_branch, mem_zero, mem_jump, mem_access, dmem_ack} = '0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        mem_access = 1'b1;
        mem_jump = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
        tick();
        expect_outs("reset_outs", ZERO);
        tick();
        rst = 1'b0;
        clear();
        expect_outs("idle", IDLE);
        tick();
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_outs($sformatf("memwait_%0d", i), STALL);
            tick();
        end
        dmem_ack = 1'b1;
        expect_outs("mem_ack", IDLEM);
        tick();
        clear();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        expect_outs("load_use_rs1", LU);
        tick();
        clear();
        expect_outs("after_load_use", IDLE);
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, 32'd4);
`endif
        ex_memread = 1'b1;
        expect_outs("x0_no_stall", IDLE);
        ex_rd = 5'd7; id_rs2 = 5'd7;
        expect_outs("rs2_unused", IDLE);
        id_uses_rs2 = 1'b1;
        expect_outs("rs2_used", LU);
        ex_memread = 1'b0;
        expect_outs("no_memread", IDLE);
        ex_memread = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
        expect_outs("branch_over_lu", RDR);
        mem_zero = 1'b0;
        expect_outs("branch_not_taken_lu", LU);
        mem_branch = 1'b0; mem_jump = 1'b1;
        expect_outs("jump", RDR);
        mem_access = 1'b1; dmem_ack = 1'b1;
        expect_outs("jump_mem_ack", RDRM);
        tick();
        clear();
        mem_access = 1'b1;
        expect_outs("wait_lu_start", STALL);
        tick();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; mem_jump = 1'b1;
        expect_outs("wait_ignores_hazards", STALL);
        tick();
        mem_jump = 1'b0; dmem_ack = 1'b1;
        expect_outs("wait_ack_lu", LUM);
        tick();
        clear();
        mem_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_outs($sformatf("edge_wait_%0d", i), STALL);
            tick();
        end
        dmem_ack = 1'b1;
        expect_outs("ack_at_limit", IDLEM);
        tick();
        clear();
        expect_outs("idle_after_limit", IDLE);
        mem_access = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_outs($sformatf("to_wait_%0d", i), STALL);
            tick();
        end
        expect_outs("timeout_err", ERRS);
        dmem_ack = 1'b1; mem_jump = 1'b1;
        tick();
        expect_outs("err_sticky", ERRS);
        rst = 1'b1;
        tick();
        expect_outs("err_reset", ZERO);
        rst = 1'b0;
        clear();
        expect_outs("run_after_reset", IDLE);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
